weight_load_sequencer: RTL and testbench
========================================

WEIGHT_LOAD_SEQUENCER -- requirements
Module: weight_load_sequencer

Interface
REQ-001 SHALL have parameter N_MACS, default 4: number of MAC columns; must be even and at least 2.
REQ-002 SHALL have parameter K_ROWS, default 4: weights per MAC.
REQ-003 SHALL have parameter ADDR_W, default 8: weight-memory address width.
REQ-004 SHALL have parameter DATA_W, default 8: weight width.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have cmd_valid  in  1  layer-load request; cmd_ready  out  1  request accepted when both high.
REQ-007 SHALL have cmd_base  in  ADDR_W  first weight address of the layer.
REQ-008 SHALL have mem_rd_en  out  1, mem_addr  out  ADDR_W, mem_rd_data  in  DATA_W: weight memory read port; read data arrives exactly 1 cycle after mem_rd_en.
REQ-009 SHALL have w_data  out  DATA_W, w_load_en  out  N_MACS (one-hot), w_row  out  clog2(K_ROWS), w_bank  out  1: weight write port into the shadow bank of the MAC array.
REQ-010 SHALL have act_bank  out  1: bank used by compute.
REQ-011 SHALL have compute_start  out  1: 1-cycle start pulse.
REQ-012 SHALL have compute_done  in  1: 1-cycle compute completion.
REQ-013 SHALL have busy  out  1 and layer_cnt  out  8: number of layers started.

Function
REQ-014 SHALL implement states IDLE, LOAD, DRAIN and ARMED, plus an independent compute_active flag.
REQ-015 SHALL assert cmd_ready only in IDLE; an accepted command latches cmd_base and moves to LOAD on the next cycle.
REQ-016 In LOAD, SHALL issue one read per cycle for index i = 0..N_MACS*K_ROWS-1 at mem_addr = cmd_base + i modulo 2^ADDR_W (address wraps).
REQ-017 SHALL move from LOAD to DRAIN after issuing the last read, and from DRAIN to ARMED after one cycle.
REQ-018 For each read index i, one cycle after the read SHALL drive w_data = mem_rd_data, w_load_en = 1 << (i / K_ROWS), w_row = i % K_ROWS, w_bank = ~act_bank.
REQ-019 SHALL hold w_load_en at zero on all other cycles.
REQ-020 In ARMED, when compute_active = 0 or compute_done = 1, SHALL in the same cycle toggle act_bank, pulse compute_start, set compute_active, increment layer_cnt (wrapping 255 -> 0), and return to IDLE.
REQ-021 SHALL clear compute_active on compute_done, except in the simultaneous ARMED swap case of REQ-020, where it stays set.
REQ-022 SHALL ignore compute_done while compute_active = 0.
REQ-023 SHALL allow loading of the next layer (IDLE/LOAD/DRAIN) to overlap an active compute; loads always target the non-active bank.
REQ-024 SHALL register all outputs; busy = (state != IDLE) | compute_active.

Reset
REQ-025 On rst, SHALL enter IDLE and clear compute_active, act_bank, layer_cnt, mem_rd_en, mem_addr, w_load_en, w_data, w_row, w_bank and compute_start to 0, with cmd_ready = 1 from the first cycle after reset.
REQ-026 Reset mid-LOAD/DRAIN SHALL discard in-flight read data: no w_load_en pulse follows reset.

Structure
REQ-027 State encodings and the bank/width constants SHALL live in shared package weight_seq_pkg.
REQ-028 The index/address counter (i, mac index, row, wrap, last flag) SHALL be sub-module weight_addr_gen.

Verification
REQ-029 Bench SHALL cover: reset, then cmd_base = 0x10 -> 16 reads at 0x10..0x1F; w_load_en 0001 x4, 0010 x4, 0100 x4, 1000 x4; w_bank = 1; compute_start 18 cycles after acceptance; act_bank = 1, layer_cnt = 1.
REQ-030 Bench SHALL cover: cmd_base = 0xFA -> addresses 0xFA..0xFF then 0x00..0x09 (wrap).
REQ-031 Bench SHALL cover: a second command during active compute -> loads into bank 0, holds ARMED until compute_done, then compute_start with act_bank = 0.
REQ-032 Bench SHALL cover: compute_done coincident with ARMED -> swap the same cycle, compute_active stays 1, busy stays 1.
REQ-033 Bench SHALL cover: rst asserted at read index 7 -> no further w_load_en, all outputs 0, cmd_ready = 1 the next cycle.
REQ-034 Bench SHALL cover: stray compute_done in IDLE -> no state or output change.

Source files
------------

// File: rtl/weight_seq_pkg.sv
// rtl/weight_seq_pkg.sv - shared states and constants for the weight load sequencer
// Contents: sequencer state encoding, bank/width constants, width helper.
package weight_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ARMED = 2'd3
    } seq_state_t;

    localparam logic BANK_0      = 1'b0;
    localparam int   BANK_W      = 1;
    localparam int   LAYER_CNT_W = 8;

    // Index width that stays legal (>= 1 bit) for single-entry ranges.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_addr_gen.sv
// rtl/weight_addr_gen.sv - read index / address counter for one layer load
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, base       restart the walk at index 0, address base
//   advance           step to the next index
//   addr              current read address (wraps modulo 2^ADDR_W)
//   mac_idx, row      current index split into MAC column and row
//   last              current index is the final one of the layer
module weight_addr_gen
    import weight_seq_pkg::*;
#(
    parameter int N_MACS = 4,
    parameter int K_ROWS = 4,
    parameter int ADDR_W = 8,
    localparam int TOTAL = N_MACS * K_ROWS,
    localparam int IDX_W = width_of(TOTAL),
    localparam int MAC_W = width_of(N_MACS),
    localparam int ROW_W = width_of(K_ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [MAC_W-1:0]  mac_idx,
    output logic [ROW_W-1:0]  row,
    output logic              last
);

    logic [IDX_W-1:0] idx;
    logic             row_wrap;

    // Row and column are counted directly instead of dividing the index.
    assign row_wrap = (row == ROW_W'(K_ROWS - 1));
    assign last     = (idx == IDX_W'(TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            addr    <= '0;
            mac_idx <= '0;
            row     <= '0;
        end else if (start) begin
            idx     <= '0;
            addr    <= base;
            mac_idx <= '0;
            row     <= '0;
        end else if (advance) begin
            idx  <= idx + 1'b1;
            addr <= addr + 1'b1;
            if (row_wrap) begin
                row     <= '0;
                mac_idx <= mac_idx + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_load_sequencer.sv
// rtl/weight_load_sequencer.sv - double-buffered weight loader for a MAC array
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_base  layer-load request and its first weight address
//   mem_rd_en/mem_addr/mem_rd_data weight memory read port, 1-cycle read latency
//   w_data/w_load_en/w_row/w_bank  write port into the shadow weight bank
//   act_bank                    bank currently used by compute
//   compute_start/compute_done  compute handshake pulses
//   busy, layer_cnt             activity flag, count of layers started
module weight_load_sequencer
    import weight_seq_pkg::*;
#(
    parameter int N_MACS = 4,
    parameter int K_ROWS = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    localparam int ROW_W = width_of(K_ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_base,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic [DATA_W-1:0]      w_data,
    output logic [N_MACS-1:0]      w_load_en,
    output logic [ROW_W-1:0]       w_row,
    output logic                   w_bank,
    output logic                   act_bank,
    output logic                   compute_start,
    input  logic                   compute_done,
    output logic                   busy,
    output logic [LAYER_CNT_W-1:0] layer_cnt
);

    localparam int MAC_W = width_of(N_MACS);

    seq_state_t       state, next_state;
    logic             compute_active;
    logic             accept, swap, gen_last, gen_advance;
    logic [MAC_W-1:0] gen_mac, pend_mac;
    logic [ROW_W-1:0] gen_row, pend_row;
    logic             pend_valid;
    logic             active_d, cmd_ready_d, rd_en_d, busy_d;

    assign accept      = cmd_valid & cmd_ready;
    assign gen_advance = (state == ST_LOAD) & ~gen_last;
    // Swap banks when the previous compute is finished or finishing now.
    assign swap        = (state == ST_ARMED) & (~compute_active | compute_done);

    weight_addr_gen #(
        .N_MACS (N_MACS),
        .K_ROWS (K_ROWS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .base    (cmd_base),
        .advance (gen_advance),
        .addr    (mem_addr),
        .mac_idx (gen_mac),
        .row     (gen_row),
        .last    (gen_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept)   next_state = ST_LOAD;
            ST_LOAD:  if (gen_last) next_state = ST_DRAIN;
            ST_DRAIN:               next_state = ST_ARMED;
            ST_ARMED: if (swap)     next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    // Registered outputs are loaded from next-cycle values so they line up
    // with the state they describe.
    always_comb begin
        active_d = compute_active;
        if (swap)
            active_d = 1'b1;
        else if (compute_done & compute_active)
            active_d = 1'b0;
        cmd_ready_d = (next_state == ST_IDLE);
        rd_en_d     = (next_state == ST_LOAD);
        busy_d      = (next_state != ST_IDLE) | active_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            compute_active <= 1'b0;
            act_bank       <= BANK_0;
            layer_cnt      <= '0;
            compute_start  <= 1'b0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            mem_rd_en      <= 1'b0;
            pend_valid     <= 1'b0;
            pend_mac       <= '0;
            pend_row       <= '0;
            w_load_en      <= '0;
            w_data         <= '0;
            w_row          <= '0;
            w_bank         <= BANK_0;
        end else begin
            compute_active <= active_d;
            compute_start  <= swap;
            cmd_ready      <= cmd_ready_d;
            busy           <= busy_d;
            mem_rd_en      <= rd_en_d;
            if (swap) begin
                act_bank  <= ~act_bank;
                layer_cnt <= layer_cnt + 1'b1;
            end
            // Remember where the outstanding read goes; its data lands next cycle.
            pend_valid <= mem_rd_en;
            pend_mac   <= gen_mac;
            pend_row   <= gen_row;
            if (pend_valid) begin
                w_load_en <= N_MACS'(1) << pend_mac;
                w_data    <= mem_rd_data;
                w_row     <= pend_row;
                w_bank    <= ~act_bank;
            end else begin
                w_load_en <= '0;
            end
        end
    end

endmodule

// File: tb/tb_weight_load_sequencer.sv
// tb/tb_weight_load_sequencer.sv - self-checking bench for weight_load_sequencer
module tb_weight_load_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_base = 8'h00;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic [7:0] w_data;
    logic [3:0] w_load_en;
    logic [1:0] w_row;
    logic       w_bank;
    logic       act_bank;
    logic       compute_start;
    logic       compute_done = 1'b0;
    logic       busy;
    logic [7:0] layer_cnt;

    typedef struct {
        logic [7:0] data;
        logic [3:0] en;
        logic [1:0] row;
        logic       bank;
    } wr_t;

    logic [7:0] exp_rd_q[$];
    wr_t        exp_wr_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 0;
    logic       exp_act_bank = 1'b0;
    logic [7:0] mon_a;
    wr_t        mon_w;

    weight_load_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base      (cmd_base),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .w_data        (w_data),
        .w_load_en     (w_load_en),
        .w_row         (w_row),
        .w_bank        (w_bank),
        .act_bank      (act_bank),
        .compute_start (compute_start),
        .compute_done  (compute_done),
        .busy          (busy),
        .layer_cnt     (layer_cnt)
    );

    always #5 clk = ~clk;

    // Weight memory: content is a fixed function of the address, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) mem_rd_data <= mem_addr ^ 8'h5A;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard monitor: every read and every shadow-bank write is popped
    // from the expectation queues filled when the command was driven.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd_en === 1'b1) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr: unexpected read at %h", mem_addr);
                end else begin
                    mon_a = exp_rd_q.pop_front();
                    if (mem_addr !== mon_a) begin
                        errors++;
                        $display("FAIL rd_addr: got %h expected %h", mem_addr, mon_a);
                    end
                end
            end
            if (w_load_en !== 4'b0000) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: w_load_en=%b", w_load_en);
                end else begin
                    mon_w = exp_wr_q.pop_front();
                    if ({w_data, w_load_en, w_row, w_bank} !==
                        {mon_w.data, mon_w.en, mon_w.row, mon_w.bank}) begin
                        errors++;
                        $display("FAIL wr_port: got data=%h en=%b row=%0d bank=%b expected data=%h en=%b row=%0d bank=%b",
                                 w_data, w_load_en, w_row, w_bank,
                                 mon_w.data, mon_w.en, mon_w.row, mon_w.bank);
                    end
                end
            end
        end
    end

    task automatic push_load(input logic [7:0] base, input logic bank);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] a;
            wr_t        w;
            a = base + 8'(i);
            exp_rd_q.push_back(a);
            w.data = a ^ 8'h5A;
            w.en   = 4'b0001 << (i / 4);
            w.row  = 2'(i % 4);
            w.bank = bank;
            exp_wr_q.push_back(w);
        end
    endtask

    task automatic issue_cmd(input logic [7:0] base, output time t_acc);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_base  = base;
        push_load(base, ~exp_act_bank);
        @(posedge clk);
        t_acc = $time;
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        checks++;
        if ({mem_rd_en, mem_addr, w_load_en, w_data, w_row, w_bank} !== 24'h0) begin
            errors++;
            $display("FAIL reset_ports: got rd_en=%b addr=%h en=%b data=%h row=%0d bank=%b expected all 0",
                     mem_rd_en, mem_addr, w_load_en, w_data, w_row, w_bank);
        end
        checks++;
        if ({act_bank, compute_start, busy, layer_cnt} !== 11'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got act_bank=%b start=%b busy=%b layer_cnt=%0d expected all 0",
                     act_bank, compute_start, busy, layer_cnt);
        end
    endtask

    task automatic test_basic;
        time t;
        bit  seen;
        int  lat;
        issue_cmd(8'h10, t);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (compute_start === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL basic_start: compute_start not seen, expected within 40 cycles");
        end else begin
            lat = int'(($time - t - 5) / 10);
            checks++;
            if (lat != 18) begin
                errors++;
                $display("FAIL basic_latency: got %0d expected 18", lat);
            end
            checks++;
            if ({act_bank, layer_cnt, busy} !== {1'b1, 8'd1, 1'b1}) begin
                errors++;
                $display("FAIL basic_swap: got act_bank=%b layer_cnt=%0d busy=%b expected 1 1 1",
                         act_bank, layer_cnt, busy);
            end
        end
        exp_act_bank = 1'b1;
        checks++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: got %0d reads %0d writes outstanding expected 0 0",
                     exp_rd_q.size(), exp_wr_q.size());
        end
        @(negedge clk);
        checks++;
        if ({compute_start, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_pulse: got start=%b cmd_ready=%b expected 0 1", compute_start, cmd_ready);
        end
    endtask

    task automatic test_overlap_wrap;
        time t;
        int  starts;
        issue_cmd(8'hFA, t);
        starts = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (compute_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL overlap_hold: got %0d compute_start pulses expected 0", starts);
        end
        checks++;
        if ({busy, cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL overlap_armed: got busy=%b cmd_ready=%b expected 1 0", busy, cmd_ready);
        end
        checks++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL overlap_drain: got %0d reads %0d writes outstanding expected 0 0",
                     exp_rd_q.size(), exp_wr_q.size());
        end
        @(posedge clk);
        #1 compute_done = 1'b1;
        @(posedge clk);
        #1 compute_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({compute_start, act_bank, layer_cnt, busy} !== {1'b1, 1'b0, 8'd2, 1'b1}) begin
            errors++;
            $display("FAIL overlap_swap: got start=%b act_bank=%b layer_cnt=%0d busy=%b expected 1 0 2 1",
                     compute_start, act_bank, layer_cnt, busy);
        end
        exp_act_bank = 1'b0;
    endtask

    task automatic test_done_at_armed;
        time t;
        int  lat;
        issue_cmd(8'h33, t);
        repeat (17) @(posedge clk);
        #1 compute_done = 1'b1;
        @(posedge clk);
        #1 compute_done = 1'b0;
        @(negedge clk);
        lat = int'(($time - t - 5) / 10);
        checks++;
        if (compute_start !== 1'b1 || lat != 18) begin
            errors++;
            $display("FAIL armed_done_start: got start=%b at %0d expected 1 at 18", compute_start, lat);
        end
        checks++;
        if ({act_bank, layer_cnt} !== {1'b1, 8'd3}) begin
            errors++;
            $display("FAIL armed_done_swap: got act_bank=%b layer_cnt=%0d expected 1 3", act_bank, layer_cnt);
        end
        exp_act_bank = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({busy, cmd_ready} !== 2'b11) begin
                errors++;
                $display("FAIL armed_done_active: got busy=%b cmd_ready=%b expected 1 1", busy, cmd_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stray_done;
        @(posedge clk);
        #1 compute_done = 1'b1;
        @(posedge clk);
        #1 compute_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL done_clears: got busy=%b cmd_ready=%b expected 0 1", busy, cmd_ready);
        end
        @(posedge clk);
        #1 compute_done = 1'b1;
        @(posedge clk);
        #1 compute_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, compute_start, mem_rd_en, w_load_en, cmd_ready, act_bank, layer_cnt} !==
                {1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 8'd3}) begin
                errors++;
                $display("FAIL stray_done: got busy=%b start=%b rd_en=%b en=%b cmd_ready=%b act_bank=%b layer_cnt=%0d expected 0 0 0 0000 1 1 3",
                         busy, compute_start, mem_rd_en, w_load_en, cmd_ready, act_bank, layer_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_load;
        time t;
        bit  seen;
        int  stray;
        issue_cmd(8'h40, t);
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (mem_rd_en === 1'b1 && mem_addr === 8'h47) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_index7: read of 47 not seen, expected within 30 cycles");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_act_bank = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_rd_en, mem_addr, w_load_en, w_data, w_row, w_bank,
             act_bank, compute_start, busy, layer_cnt} !== 35'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got rd_en=%b addr=%h en=%b data=%h row=%0d bank=%b act=%b start=%b busy=%b cnt=%0d expected all 0",
                     mem_rd_en, mem_addr, w_load_en, w_data, w_row, w_bank,
                     act_bank, compute_start, busy, layer_cnt);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_cmd_ready: got %b expected 1", cmd_ready);
        end
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (w_load_en !== 4'b0000 || mem_rd_en !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midrst_quiet: got %0d active cycles expected 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap_wrap();
        test_done_at_armed();
        test_stray_done();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
